// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU in EX; raises div_stop to stall EX while busy.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |divisor|==0 or |dividend|<|divisor|.
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             es_valid_h,
  input  logic             div_req,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             div_cancel,
  output logic             div_stop,
  output logic             div_done,
  output logic [WIDTH-1:0] div_quot,
  output logic [WIDTH-1:0] div_rem,
  output logic [1:0]       dbg_state
);

  // Handshake: a request is taken in the IDLE cycle where es_valid_h & div_req & ~div_cancel;
  // div_stop holds EX from that cycle until the result cycle, where div_done pulses for one
  // cycle with div_stop low, so EX retires the instruction at the end of the done cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] dvsr_r;
  logic             q_neg_r;
  logic             r_neg_r;

  logic             start;
  logic             src1_neg;
  logic             src2_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quot_step;
  logic             last_step;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             early_hit;
  logic             unused_diff_bit;

  assign dbg_state = state;

  assign start    = resetn & (state == S_IDLE) & es_valid_h & div_req & ~div_cancel;
  assign src1_neg = div_signed & div_src1[WIDTH-1];
  assign src2_neg = div_signed & div_src2[WIDTH-1];
  assign a_mag    = src1_neg ? -div_src1 : div_src1;
  assign b_mag    = src2_neg ? -div_src2 : div_src2;

  // Partial remainder is WIDTH+1 bits after the shift; the extra top bit of diff is the borrow.
  assign shifted         = {rem_r, quot_r[WIDTH-1]};
  assign diff            = {1'b0, shifted} - {2'b00, dvsr_r};
  assign borrow          = diff[WIDTH+1];
  assign unused_diff_bit = diff[WIDTH];
  assign rem_step        = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quot_step       = {quot_r[WIDTH-2:0], ~borrow};
  assign last_step       = (state == S_BUSY) && (cnt == CNT_W'(WIDTH - 1));
  assign q_fix           = q_neg_r ? -quot_step : quot_step;
  assign r_fix           = r_neg_r ? -rem_step : rem_step;

`ifdef DIV_EARLY_OUT_EN
  logic [WIDTH-1:0] early_q_mag;
  logic [WIDTH-1:0] early_q;

  assign early_hit   = (b_mag == '0) || (a_mag < b_mag);
  assign early_q_mag = (b_mag == '0) ? '1 : '0;
  assign early_q     = (src1_neg ^ src2_neg) ? -early_q_mag : early_q_mag;
`else
  assign early_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = early_hit ? S_DONE : S_BUSY;
          cnt_nxt   = '0;
        end
      end
      S_BUSY: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (last_step) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (div_cancel) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
  end

  assign div_stop = resetn & (start | (state == S_BUSY)) & ~div_cancel;
  assign div_done = (state == S_DONE) & ~div_cancel;

  // Results are written only on completion, so cancel leaves the previous LO/HI visible.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_r    <= '0;
      quot_r   <= '0;
      dvsr_r   <= '0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      div_quot <= '0;
      div_rem  <= '0;
    end else if (start) begin
      rem_r   <= '0;
      quot_r  <= a_mag;
      dvsr_r  <= b_mag;
      q_neg_r <= src1_neg ^ src2_neg;
      r_neg_r <= src1_neg;
`ifdef DIV_EARLY_OUT_EN
      if (early_hit) begin
        div_quot <= early_q;
        div_rem  <= div_src1;
      end
`endif
    end else if ((state == S_BUSY) && !div_cancel) begin
      rem_r  <= rem_step;
      quot_r <= quot_step;
      if (last_step) begin
        div_quot <= q_fix;
        div_rem  <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Bench for div_iter_unit: directed vector table, cancel/reset/back-to-back sequences, random ops.
// Honors DIV_EARLY_OUT_EN for expected latency.
module tb_div_iter_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         es_valid_h = 1'b0;
  logic         div_req = 1'b0;
  logic         div_signed = 1'b0;
  logic [W-1:0] div_src1 = '0;
  logic [W-1:0] div_src2 = '0;
  logic         div_cancel = 1'b0;
  logic         div_stop;
  logic         div_done;
  logic [W-1:0] div_quot;
  logic [W-1:0] div_rem;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[10];

  div_iter_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .es_valid_h (es_valid_h),
    .div_req    (div_req),
    .div_signed (div_signed),
    .div_src1   (div_src1),
    .div_src2   (div_src2),
    .div_cancel (div_cancel),
    .div_stop   (div_stop),
    .div_done   (div_done),
    .div_quot   (div_quot),
    .div_rem    (div_rem),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: divide magnitudes with plain arithmetic, then apply the sign rules.
  task automatic ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic early);
    logic         an, bn;
    logic [W-1:0] ma, mb, mq, mr;
    an = sgn & a[W-1];
    bn = sgn & b[W-1];
    ma = an ? (~a + 1'b1) : a;
    mb = bn ? (~b + 1'b1) : b;
    if (mb == 0) begin
      mq = '1;
      mr = ma;
    end else begin
      mq = ma / mb;
      mr = ma % mb;
    end
    q = (an ^ bn) ? (~mq + 1'b1) : mq;
    r = an ? (~mr + 1'b1) : mr;
    early = (mb == 0) || (ma < mb);
  endtask

  // Caller must be at posedge+#1 of the request cycle; returns in the done cycle.
  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag, output logic [W-1:0] got_q, output logic [W-1:0] got_r);
    logic [W-1:0] q, r;
    logic         early;
    int           lat, exp_lat;
    logic         seen;
    ref_div(sgn, a, b, q, r, early);
    exp_q.push_back(q);
    exp_r.push_back(r);
`ifdef DIV_EARLY_OUT_EN
    exp_lat = early ? 1 : W + 1;
`else
    exp_lat = W + 1;
`endif
    es_valid_h = 1'b1;
    div_req    = 1'b1;
    div_signed = sgn;
    div_src1   = a;
    div_src2   = b;
    #1;
    chk_b({tag, " stop_at_req"}, div_stop, 1'b1);
    seen = 1'b0;
    lat  = 0;
    got_q = '0;
    got_r = '0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(posedge clk);
      #2;
      if (div_done) begin
        seen = 1'b1;
        lat  = c;
      end else begin
        if (c == 1) chk({tag, " hold_quot"}, div_quot, last_q);
        if (c <= W && exp_lat > 1) chk_b({tag, " stop_busy"}, div_stop, 1'b1);
      end
    end
    chk_b({tag, " done_seen"}, seen, 1'b1);
    q = exp_q.pop_front();
    r = exp_r.pop_front();
    if (seen) begin
      chk({tag, " latency"}, W'(lat), W'(exp_lat));
      chk_b({tag, " stop_in_done"}, div_stop, 1'b0);
      chk({tag, " quot"}, div_quot, q);
      chk({tag, " rem"}, div_rem, r);
      got_q  = div_quot;
      got_r  = div_rem;
      last_q = q;
      last_r = r;
    end
    div_req    = 1'b0;
    es_valid_h = 1'b0;
  endtask

  initial begin
    logic [W-1:0] gq, gr, a, b;
    logic         sgn;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0};
    vecs[4] = '{1'b0, 32'd5,          32'd0,        32'hFFFFFFFF, 32'd5};
    vecs[5] = '{1'b0, 32'd3,          32'd10,       32'd0,        32'd3};
    vecs[6] = '{1'b0, 32'd9,          32'd3,        32'd3,        32'd0};
    vecs[7] = '{1'b1, 32'hFFFFFFFB,   32'd0,        32'd1,        32'hFFFFFFFB};
    vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0};
    vecs[9] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE};

    // reset: request held during reset must not raise div_stop
    es_valid_h = 1'b1;
    div_req    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_b("reset stop", div_stop, 1'b0);
    chk_b("reset done", div_done, 1'b0);
    chk("reset quot", div_quot, '0);
    chk("reset rem", div_rem, '0);
    div_req    = 1'b0;
    es_valid_h = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // directed vector table
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), gq, gr);
      chk($sformatf("vec%0d table_quot", i), gq, vecs[i].q);
      chk($sformatf("vec%0d table_rem", i), gr, vecs[i].r);
    end

    // cancel mid-operation, restart in the following cycle
    @(posedge clk);
    #1;
    es_valid_h = 1'b1;
    div_req    = 1'b1;
    div_signed = 1'b0;
    div_src1   = 32'd100;
    div_src2   = 32'd7;
    #1;
    chk_b("cancel stop_at_req", div_stop, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1;
      chk_b("cancel busy_stop", div_stop, 1'b1);
      chk_b("cancel busy_done", div_done, 1'b0);
    end
    @(posedge clk);
    #1;
    div_cancel = 1'b1;
    #1;
    chk_b("cancel stop_drop", div_stop, 1'b0);
    chk_b("cancel no_done", div_done, 1'b0);
    @(posedge clk);
    #1;
    div_cancel = 1'b0;
    chk_b("cancel after_done", div_done, 1'b0);
    chk("cancel quot_kept", div_quot, last_q);
    chk("cancel rem_kept", div_rem, last_r);
    run_div(1'b0, 32'd9, 32'd3, "post_cancel", gq, gr);
    chk("post_cancel quot_const", gq, 32'd3);

    // back-to-back: next request in the cycle right after done
    @(posedge clk);
    #1;
    run_div(1'b0, 32'd1000, 32'd3, "b2b_first", gq, gr);
    @(posedge clk);
    #1;
    run_div(1'b1, 32'hFFFFFC18, 32'd7, "b2b_second", gq, gr);

    // asynchronous reset while busy
    @(posedge clk);
    #1;
    es_valid_h = 1'b1;
    div_req    = 1'b1;
    div_signed = 1'b0;
    div_src1   = 32'd12345;
    div_src2   = 32'd6;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk_b("midreset stop", div_stop, 1'b0);
    chk_b("midreset done", div_done, 1'b0);
    chk("midreset quot", div_quot, '0);
    chk("midreset rem", div_rem, '0);
    div_req    = 1'b0;
    es_valid_h = 1'b0;
    last_q     = '0;
    last_r     = '0;
    @(negedge clk);
    resetn = 1'b1;

    // randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = (sgn && $urandom_range(0, 1) == 1) ? -W'($urandom_range(1, 15)) : W'($urandom_range(1, 300));
        default: begin
          b = $urandom;
          a = a >> $urandom_range(0, 31);
        end
      endcase
      if ($urandom_range(0, 9) == 0) b = '0;
      @(posedge clk);
      #1;
      run_div(sgn, a, b, $sformatf("rand%0d", i), gq, gr);
    end

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
